// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared types, constants and helpers for the pipelined
//               carry-lookahead adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    // Operation select: add, or subtract by inverting B and forcing carry-in.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Lookahead group size inside every slice.
    localparam int GROUP = 4;

    // Two's-complement overflow: like-signed operands producing an
    // opposite-signed result.
    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_slice.sv
`default_nettype none
// ============================================================================
// Module      : cla_slice
// Description : Combinational SW-bit adder slice built from 4-bit
//               carry-lookahead groups, with group-level carry chaining.
//               Also exposes the carry into the slice MSB for overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_slice
    import cla_pkg::*;
#(
    parameter int SW = 16
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          c_msb_in
);

    localparam int c_NG = SW / GROUP;

    logic [SW-1:0]   w_p;
    logic [SW-1:0]   w_g;
    logic [SW-1:0]   w_bc;
    logic [c_NG-1:0] w_gp;
    logic [c_NG-1:0] w_gg;
    // Unpacked so each group carry is its own node in the carry chain.
    logic            w_gc [c_NG+1];

    assign w_p   = a ^ b;
    assign w_g   = a & b;
    assign w_gc[0] = cin;

    generate
        for (genvar j = 0; j < c_NG; j++) begin : g_grp
            localparam int c_B = j * GROUP;

            // Group propagate / generate.
            assign w_gp[j] = &w_p[c_B +: GROUP];
            assign w_gg[j] = w_g[c_B+3]
                           | (w_p[c_B+3] & w_g[c_B+2])
                           | (w_p[c_B+3] & w_p[c_B+2] & w_g[c_B+1])
                           | (w_p[c_B+3] & w_p[c_B+2] & w_p[c_B+1] & w_g[c_B]);

            // Carry into the next group.
            assign w_gc[j+1] = w_gg[j] | (w_gp[j] & w_gc[j]);

            // Bit carries inside the group, all flattened from the group carry-in.
            assign w_bc[c_B]   = w_gc[j];
            assign w_bc[c_B+1] = w_g[c_B] | (w_p[c_B] & w_gc[j]);
            assign w_bc[c_B+2] = w_g[c_B+1]
                               | (w_p[c_B+1] & w_g[c_B])
                               | (w_p[c_B+1] & w_p[c_B] & w_gc[j]);
            assign w_bc[c_B+3] = w_g[c_B+2]
                               | (w_p[c_B+2] & w_g[c_B+1])
                               | (w_p[c_B+2] & w_p[c_B+1] & w_g[c_B])
                               | (w_p[c_B+2] & w_p[c_B+1] & w_p[c_B] & w_gc[j]);
        end
    endgenerate

    assign sum      = w_p ^ w_bc;
    assign cout     = w_gc[c_NG];
    assign c_msb_in = w_bc[SW-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_cla.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_cla
// Description : Pipelined carry-lookahead adder/subtractor. Operands are cut
//               into STAGES slices; stage k adds slice k with the carry
//               registered by stage k-1. Upper operand slices ride along
//               right-aligned, completed sum slices are shifted in from the
//               top. Single global advance gives valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cla
    import cla_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  op_e              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int c_SW = WIDTH / STAGES;

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    // Per-stage pipeline registers.
    logic             r_vld [STAGES];
    logic             r_c   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];

    // Per-stage combinational slice inputs / outputs and next-state values.
    logic [c_SW-1:0]  w_sa   [STAGES];
    logic [c_SW-1:0]  w_sb   [STAGES];
    logic [c_SW-1:0]  w_ss   [STAGES];
    logic             w_sci  [STAGES];
    logic             w_sco  [STAGES];
    logic             w_cmsb [STAGES];
    logic             w_vin  [STAGES];
    logic [WIDTH-1:0] w_nsum [STAGES];
    logic [WIDTH-1:0] w_na   [STAGES];
    logic [WIDTH-1:0] w_nb   [STAGES];

    logic             r_ovf;
    logic             r_zero;
    logic             w_s_msb;

    // Whole pipe moves together: it advances unless a held result is blocked.
    assign w_adv    = !r_vld[STAGES-1] || out_ready;
    assign in_ready = w_adv;

    // Subtraction becomes A + ~B + 1 before the first slice sees the operands.
    assign w_b_eff   = (op == OP_SUB) ? ~B : B;
    assign w_cin_eff = (op == OP_SUB) ? 1'b1 : Cin;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign w_sa[k]  = A[c_SW-1:0];
                assign w_sb[k]  = w_b_eff[c_SW-1:0];
                assign w_sci[k] = w_cin_eff;
                assign w_vin[k] = in_valid;
                if (STAGES == 1) begin : g_full
                    assign w_nsum[k] = w_ss[k];
                end else begin : g_part
                    assign w_nsum[k] = {w_ss[k], {(WIDTH-c_SW){1'b0}}};
                end
            end else begin : g_next
                assign w_sa[k]   = r_a[k-1][c_SW-1:0];
                assign w_sb[k]   = r_b[k-1][c_SW-1:0];
                assign w_sci[k]  = r_c[k-1];
                assign w_vin[k]  = r_vld[k-1];
                assign w_nsum[k] = {w_ss[k], r_sum[k-1][WIDTH-1:c_SW]};
            end

            // Remaining upper operand bits, shifted down so the next slice is at bit 0.
            if (k == STAGES-1) begin : g_up_last
                assign w_na[k] = '0;
                assign w_nb[k] = '0;
            end else if (k == 0) begin : g_up_first
                assign w_na[k] = {{c_SW{1'b0}}, A[WIDTH-1:c_SW]};
                assign w_nb[k] = {{c_SW{1'b0}}, w_b_eff[WIDTH-1:c_SW]};
            end else begin : g_up_mid
                assign w_na[k] = {{c_SW{1'b0}}, r_a[k-1][WIDTH-1:c_SW]};
                assign w_nb[k] = {{c_SW{1'b0}}, r_b[k-1][WIDTH-1:c_SW]};
            end

            cla_slice #(
                .SW (c_SW)
            ) u_slice (
                .a        (w_sa[k]),
                .b        (w_sb[k]),
                .cin      (w_sci[k]),
                .sum      (w_ss[k]),
                .cout     (w_sco[k]),
                .c_msb_in (w_cmsb[k])
            );
        end
    endgenerate

    // Stage registers: load together on advance, clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_c[k]   <= 1'b0;
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_vin[k];
                r_c[k]   <= w_sco[k];
                r_sum[k] <= w_nsum[k];
                r_a[k]   <= w_na[k];
                r_b[k]   <= w_nb[k];
            end
        end
    end

    // Result MSB rebuilt from the carry into it, so overflow needs no sum-bit fanout.
    assign w_s_msb = w_sa[STAGES-1][c_SW-1] ^ w_sb[STAGES-1][c_SW-1] ^ w_cmsb[STAGES-1];

    // Flags are produced by the last stage alongside the final sum slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv) begin
            r_ovf  <= ovf_f(w_sa[STAGES-1][c_SW-1], w_sb[STAGES-1][c_SW-1], w_s_msb);
            r_zero <= (w_nsum[STAGES-1] == '0);
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign Sum       = r_sum[STAGES-1];
    assign Cout      = r_c[STAGES-1];
    assign Ovf       = r_ovf;
    assign Zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_cla
// Description : Self-checking bench for pipelined_cla. Three instances
//               (STAGES = 4, 2, 1) share the stimulus; a scoreboard queue
//               holds model results tagged with instance and issue cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_cla;
    import cla_pkg::*;

    localparam int W   = 64;
    localparam int c_N = 3;

    typedef struct {
        int         dut;
        logic [W-1:0] s;
        logic       co;
        logic       ov;
        logic       z;
        int         acc;
        int         stl;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    op_e          op = OP_ADD;

    logic         inr  [c_N];
    logic         outv [c_N];
    logic         ordy [c_N];
    logic         co_o [c_N];
    logic         ov_o [c_N];
    logic         z_o  [c_N];
    logic [W-1:0] sum_o [c_N];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   stl [c_N] = '{0, 0, 0};
    int   ret [c_N] = '{0, 0, 0};
    exp_t sb [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign ordy[0] = out_ready;
    assign ordy[1] = 1'b1;
    assign ordy[2] = 1'b1;

    function automatic int stages_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
    endfunction

    generate
        for (genvar d = 0; d < c_N; d++) begin : g_dut
            localparam int c_ST = (d == 0) ? 4 : ((d == 1) ? 2 : 1);
            pipelined_cla #(
                .WIDTH  (W),
                .STAGES (c_ST)
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (inr[d]),
                .A         (a),
                .B         (b),
                .Cin       (cin),
                .op        (op),
                .out_valid (outv[d]),
                .out_ready (ordy[d]),
                .Sum       (sum_o[d]),
                .Cout      (co_o[d]),
                .Ovf       (ov_o[d]),
                .Zero      (z_o[d])
            );
        end
    endgenerate

    // Reference: wide unsigned sum for carry, sign-extended sum for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input op_e o);
        exp_t              e;
        logic [W-1:0]      be;
        logic              ce;
        logic [W:0]        r;
        logic signed [W+1:0] sr;
        be = (o == OP_SUB) ? ~y : y;
        ce = (o == OP_SUB) ? 1'b1 : c;
        r  = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, ce};
        sr = $signed({{2{x[W-1]}}, x}) + $signed({{2{be[W-1]}}, be}) + $signed({{(W+1){1'b0}}, ce});
        e.dut = 0;
        e.s   = r[W-1:0];
        e.co  = r[W];
        e.ov  = (sr[W] != sr[W-1]);
        e.z   = (r[W-1:0] == '0);
        e.acc = 0;
        e.stl = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int expv);
        n_vec++;
        assert (obs == expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor: decisions at the falling edge describe the next rising edge.
    always @(negedge clk) begin : mon
        exp_t e;
        int   idx;
        if (!rst_n) begin
            sb.delete();
            for (int d = 0; d < c_N; d++) ret[d] = 0;
        end else begin
            for (int d = 0; d < c_N; d++) begin
                if (outv[d] && ordy[d]) begin
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++)
                        if (idx < 0 && sb[i].dut == d) idx = i;
                    ret[d]++;
                    if (idx < 0) begin
                        chk1($sformatf("d%0d unexpected_result", d), outv[d], 1'b0);
                    end else begin
                        e = sb[idx];
                        sb.delete(idx);
                        chk ($sformatf("d%0d sum", d),  sum_o[d], e.s);
                        chk1($sformatf("d%0d cout", d), co_o[d],  e.co);
                        chk1($sformatf("d%0d ovf", d),  ov_o[d],  e.ov);
                        chk1($sformatf("d%0d zero", d), z_o[d],   e.z);
                        chki($sformatf("d%0d latency", d), cyc - e.acc,
                             stages_of(d) + stl[d] - e.stl);
                    end
                end
                if (outv[d] && !ordy[d]) stl[d]++;
                if (in_valid && inr[d]) begin
                    e     = model(a, b, cin, op);
                    e.dut = d;
                    e.acc = cyc;
                    e.stl = stl[d];
                    sb.push_back(e);
                end
            end
        end
    end

    function automatic logic [W-1:0] front_sum(input int d);
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].dut == d) return sb[i].s;
        return 'x;
    endfunction

    // Present one operation (called just after a rising edge) and hold it until accepted.
    task automatic send(input op_e o, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int t;
        in_valid = 1'b1;
        op  = o;
        a   = x;
        b   = y;
        cin = c;
        t   = 0;
        @(negedge clk);
        while (!inr[0] && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (t >= 100) chk1("accept_timeout", inr[0], 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(op_e'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chki("drain_outstanding", sb.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Reset state, visible before any clock edge.
        #1;
        for (int d = 0; d < c_N; d++) begin
            chk1($sformatf("d%0d rst out_valid", d), outv[d], 1'b0);
            chk ($sformatf("d%0d rst sum", d), sum_o[d], '0);
            chk1($sformatf("d%0d rst cout", d), co_o[d], 1'b0);
            chk1($sformatf("d%0d rst ovf", d),  ov_o[d], 1'b0);
            chk1($sformatf("d%0d rst zero", d), z_o[d],  1'b0);
            chk1($sformatf("d%0d rst in_ready", d), inr[d], 1'b1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed corner cases.
        send(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        send(OP_SUB, 64'd5, 64'd7, 1'b1);
        send(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        send(OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        send(OP_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        send(OP_ADD, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1);
        drain();

        // Back-to-back random traffic.
        for (int i = 0; i < 16; i++) send_rand();
        drain();

        // Stall: six ops, downstream blocked for three cycles after the first result.
        fork
            begin : f_send
                for (int i = 0; i < 6; i++) send_rand();
            end
            begin : f_stall
                int t;
                t = 0;
                @(negedge clk);
                while (!outv[0] && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                chk1("stall first_result", outv[0], 1'b1);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk1("stall in_ready", inr[0], 1'b0);
                    chk1("stall out_valid", outv[0], 1'b1);
                    chk ("stall sum_held", sum_o[0], front_sum(0));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with work in flight, then a single fresh operation.
        send_rand();
        send_rand();
        send_rand();
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < c_N; d++)
            chk1($sformatf("d%0d async_rst out_valid", d), outv[d], 1'b0);
        chk("async_rst sum", sum_o[0], '0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(OP_ADD, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1);
        drain();
        repeat (6) @(negedge clk);
        chki("post_rst results", ret[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_cla.md
# pipelined_cla

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshaking on both sides. Operands are split into `STAGES` equal slices. Each pipeline stage resolves one slice with 4-bit lookahead groups, and the slice carry is registered into the next stage. It sits in the datapath wherever a wide add must close timing at one result per cycle. It also reports carry, signed overflow and zero flags.

## Interface
- `WIDTH`, 64: operand/result width; must be a multiple of `4*STAGES`.
- `STAGES`, 4: pipeline depth and slice count; ≥1. Slice width `SW = WIDTH/STAGES`.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  operands valid.
- `in_ready`  output  1  block can accept operands this cycle.
- `A`  input  WIDTH  operand A.
- `B`  input  WIDTH  operand B.
- `Cin`  input  1  carry-in; used in add mode only.
- `op`  input  1  `cla_pkg::op_e`: `OP_ADD`=0, `OP_SUB`=1.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts result.
- `Sum`  output  WIDTH  result.
- `Cout`  output  1  carry out of bit WIDTH-1. In subtract mode, 1 means no borrow.
- `Ovf`  output  1  two's-complement signed overflow.
- `Zero`  output  1  `Sum == 0`.

## Operation
- Add: `Sum = A + B + Cin`.
- Sub: `Sum = A + ~B + 1`. `Cin` is ignored.
- Operand inversion is applied at capture, before stage 0.
- Stage k (0..STAGES-1) adds slice k, bits `[k*SW +: SW]`, using the carry registered by stage k-1. Stage 0 uses the effective carry-in.
- Upper operand slices are delayed alongside the computation. Completed lower sum slices are forwarded so that each stage holds a coherent partial result.
- Within a slice, the carry between 4-bit groups uses group propagate/generate: `C[i+1] = G | (P & C[i])`.
- `Ovf = (a_msb == b'_msb) && (sum_msb != a_msb)`, where `b'` is the possibly inverted B.
- `Zero` is computed from the final Sum in the last stage. There is no extra latency for it.
- Pipeline has a single global advance: `adv = !out_valid || out_ready`.
  - `in_ready = adv`.
  - Every stage register (data and per-stage valid bit) loads only when `adv` is high.
- A transaction is accepted on the edge where `in_valid && in_ready`.
- A result retires on the edge where `out_valid && out_ready`.
- Results always leave in issue order. Nothing is dropped or duplicated.
- Bubbles (`in_valid`=0 while `adv`=1) propagate as stage-valid=0 and never appear as `out_valid`.
- The two widths behave identically: all arithmetic is modulo 2^WIDTH, and carry/overflow come only from the top bit.

## Timing
- Reset (`rst_n`=0, asynchronous): every stage valid bit and data register clears to 0. Outputs read `out_valid`=0, `Sum`=0, `Cout`=0, `Ovf`=0, `Zero`=0. `in_ready` is 1 immediately, because it derives from `out_valid`=0.
- Reset asserted mid-operation discards all in-flight transactions. After release, the first `out_valid` can only come from an input accepted after release.
- Latency: `STAGES` cycles from the accepting edge to `out_valid`=1, with no stall.
  - With `STAGES`=1, a full-width add feeds one output register.
- Throughput: one result per cycle while `out_ready`=1.
- Stall (`out_valid`=1, `out_ready`=0):
  - All outputs hold stable.
  - `in_ready`=0 in the same cycle, combinationally.
  - No upstream acceptance occurs.
- Simultaneous retire and accept in the same cycle is legal and required. It gives full throughput.
- `Cin`/`op` are sampled only on the accepting edge. Changes while `in_ready`=0 have no effect.

## Structure
- Package `cla_pkg` holds:
  - `typedef enum logic {OP_ADD, OP_SUB} op_e`.
  - `localparam GROUP = 4`.
  - Function `ovf_f(a_msb, b_msb, s_msb)`.
- Sub-module `cla_slice #(SW)`: combinational slice adder built from 4-bit lookahead groups. It has ports `a`, `b`, `cin` → `sum`, `cout`, `c_msb_in`; `c_msb_in` is the carry into the slice MSB and is used for overflow. It is instantiated `STAGES` times in a generate loop.
- The top level owns the handshake, the skew/deskew registers and the flag generation.

## Test plan
All scenarios run at `WIDTH`=64, `STAGES`=4, and the random test is repeated at `STAGES`=1 and `STAGES`=2.
- Add `A`=0xFFFF_FFFF_FFFF_FFFF, `B`=1, `Cin`=0, `out_ready`=1 → 4 cycles later `Sum`=0, `Cout`=1, `Zero`=1, `Ovf`=0.
- Sub `A`=5, `B`=7, `Cin`=1 (ignored) → `Sum`=0xFFFF_FFFF_FFFF_FFFE, `Cout`=0, `Ovf`=0, `Zero`=0.
- Add `A`=0x7FFF_FFFF_FFFF_FFFF, `B`=1 → `Sum`=0x8000_0000_0000_0000, `Ovf`=1, `Cout`=0. Also sub `A`=0x8000_0000_0000_0000, `B`=1 → `Ovf`=1.
- 16 back-to-back random ops, `out_ready`=1 → one result per cycle from cycle 4, each matching the reference model, in order.
- 6 ops issued, with `out_ready` held 0 for 3 cycles after the first result → `in_ready`=0 and `Sum` stable during the stall, all 6 results delivered in order with none lost.
- 3 ops in flight, then `rst_n` pulsed low for 1 cycle mid-cycle → `out_valid`=0 at once. After release, a single new op produces exactly one result, 4 cycles after acceptance.
